uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter; sits directly downstream of the memory-access controller's transmit outputs (enable/data/busy handshake) and drives the FPGA TX pin.
- Accepts one byte per single-cycle enable pulse and serialises it as 8N1, LSB first.
- Reports busy so the controller can hold off until the line is free.
- One clock domain; all outputs registered.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per serial bit (12 MHz / 115200 baud); legal range 2..65535.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tx_en  input  1  start-transmit strobe; sampled only while idle.
- tx_data  input  8  byte to send; captured on the clk edge that accepts tx_en.
- tx  output  1  serial line, idle high.
- busy  output  1  high from acceptance through the end of the last stop bit.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - tx=1, busy=0, done=0; state IDLE; counters 0; shift register 0.
- Counters and shift register:
  - Baud counter width is clog2(CLKS_PER_BIT).
  - 3-bit bit index.
  - 8-bit shift register.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE:
  - tx=1, busy=0.
  - On an edge with tx_en=1: latch tx_data into the shift register, set tx=0 and busy=1 on that same edge, clear the baud counter, go to START.
  - busy is therefore already high in the cycle right after the enable pulse. The controller checks busy in that cycle and relies on this.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles.
  - On baud counter == CLKS_PER_BIT-1: counter to 0, tx=shift[0], bit index to 0, go to DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At the end of each bit: shift right, drive the next LSB, increment the bit index.
  - After bit index 7 completes: go to STOP (or PARITY), tx=1.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On completion: go to IDLE, busy=0, done=1 for exactly one cycle.
- Frame timing:
  - Frame length from the accepting edge to the busy-falling edge is exactly (1+8+STOP_BITS)*CLKS_PER_BIT cycles.
  - That is 10*CLKS_PER_BIT at defaults, 11*CLKS_PER_BIT with parity.
- tx_en while busy:
  - Ignored entirely: no latch, no queueing.
  - tx_data changes mid-frame have no effect.
- Back-to-back frames:
  - tx_en high in the first IDLE cycle (the cycle busy reads 0) starts the next frame immediately.
  - Minimum idle gap between the stop bit and the next start bit is 1 cycle.
- Simultaneous completion and tx_en:
  - tx_en on the edge where STOP completes is ignored.
  - It is accepted on the following edge if still held.
- Reset mid-frame:
  - Frame aborted; tx returns high asynchronously; busy=0.
  - No done pulse; the next tx_en after release starts a clean frame.
- Glitch-free tx: tx is a register output, never combinational.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx = even parity (XOR of the 8 latched data bits), computed from the byte captured at acceptance.
  - Frame becomes 8E1/8E2.
- Undefined:
  - No PARITY state and no parity logic synthesised; the frame is 8N1/8N2 as above.

Test Plan:
- Reset mid-frame: CLKS_PER_BIT=4; accept 0xA5, assert reset at cycle 17 -> tx=1 and busy=0 immediately; no done pulse; a new 0x01 after release transmits correctly.
- Single byte: CLKS_PER_BIT=4, pulse tx_en with 0xA5 -> tx sequence over 40 cycles (4 cycles each bit) is 0,1,0,1,0,0,1,0,1,1; busy high the cycle after the pulse for exactly 40 cycles; done pulses once at cycle 40.
- Busy handshake: hold tx_en=1 continuously with data 0x3C then 0xC3 swapped at cycle 5 -> first frame carries 0x3C; second frame starts exactly 1 cycle after busy falls, carrying the then-current data.
- Enable while busy: pulse tx_en with 0xFF at cycle 12 of a 0x00 frame -> frame unchanged (all data bits 0); no second frame.
- STOP_BITS=2, CLKS_PER_BIT=3, byte 0x80 -> stop high for 6 cycles; busy width 33 cycles.
- UART_TX_PARITY_EN defined, CLKS_PER_BIT=4: 0x07 -> parity bit 1; 0x03 -> parity bit 0; busy width 44 cycles each.

Source files
------------

// File: rtl/uart_tx_if.sv
// ============================================================================
// Module  : uart_tx_if
// Purpose : Transmit handshake between the controller (master) and uart_tx.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;

  modport master (output tx_en, output tx_data, input busy, input done);
  modport slave  (input tx_en, input tx_data, output busy, output done);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module  : uart_tx
// Purpose : 8N1/8N2 UART transmitter, LSB first, registered outputs.
//           Define UART_TX_PARITY_EN for an even-parity bit (8E1/8E2).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     tx
);

  localparam int                c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic w_bit_end;
  assign w_bit_end = (r_cnt == c_CNT_LAST);

  assign tx       = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Start bit goes out on the accepting edge so busy is visible next cycle.
          if (bus.tx_en) begin
            r_shift <= bus.tx_data;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^bus.tx_data;
`endif
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_idx   <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          // r_idx counts stop bits here; tx_en is deliberately not sampled.
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == c_STOP_LAST) begin
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module  : tb_uart_tx
// Purpose : Directed, table-driven bench for uart_tx (two parameter sets).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int A_CLKS = 4;
  localparam int A_STOP = 1;
  localparam int B_CLKS = 3;
  localparam int B_STOP = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx_a;
  logic tx_b;

  uart_tx_if ifa ();
  uart_tx_if ifb ();

  uart_tx #(.CLKS_PER_BIT(A_CLKS), .STOP_BITS(A_STOP)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ifa),
    .tx   (tx_a)
  );

  uart_tx #(.CLKS_PER_BIT(B_CLKS), .STOP_BITS(B_STOP)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ifb),
    .tx   (tx_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // frame: hand-written 10-bit frame, bit i is the i-th bit on the wire
  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[7];
  vec_t v3c, vc3, v00, va5, v01;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int which);
    return (which != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic get_busy(input int which);
    return (which != 0) ? ifb.busy : ifa.busy;
  endfunction

  function automatic logic get_done(input int which);
    return (which != 0) ? ifb.done : ifa.done;
  endfunction

  task automatic drive_en(input int which, input logic en);
    if (which != 0) ifb.tx_en = en;
    else            ifa.tx_en = en;
  endtask

  task automatic drive_data(input int which, input logic [7:0] d);
    if (which != 0) ifb.tx_data = d;
    else            ifa.tx_data = d;
  endtask

  function automatic int nbits(input int stops);
`ifdef UART_TX_PARITY_EN
    return 10 + stops;
`else
    return 9 + stops;
`endif
  endfunction

  function automatic logic [15:0] expand(input vec_t v, input int stops);
    logic [15:0] b;
    int n;
    b = '0;
    for (int i = 0; i < 9; i++) b[i] = v.frame[i];
    n = 9;
`ifdef UART_TX_PARITY_EN
    b[n] = v.par;
    n++;
`endif
    for (int s = 0; s < stops; s++) begin
      b[n] = v.frame[9];
      n++;
    end
    return b;
  endfunction

  task automatic send(input int which, input logic [7:0] d);
    @(negedge clk);
    drive_data(which, d);
    drive_en(which, 1'b1);
    @(posedge clk);
  endtask

  // Called right after the accepting edge; ends in the cycle where done is high.
  task automatic check_frame(input int which, input vec_t v, input bit hold,
                             input int inj_k, input logic inj_en,
                             input logic [7:0] inj_data, input string tag);
    int clks;
    int stops;
    int n;
    logic [15:0] bits;
    clks  = (which != 0) ? B_CLKS : A_CLKS;
    stops = (which != 0) ? B_STOP : A_STOP;
    n     = nbits(stops);
    bits  = expand(v, stops);
    for (int k = 0; k < n * clks; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) drive_en(which, 1'b0);
      if (k == inj_k) begin
        drive_en(which, inj_en);
        drive_data(which, inj_data);
      end else if (k == inj_k + 1 && !hold) begin
        drive_en(which, 1'b0);
      end
      chk($sformatf("%s tx k=%0d", tag, k), get_tx(which), bits[k / clks]);
      chk($sformatf("%s busy k=%0d", tag, k), get_busy(which), 1'b1);
      chk($sformatf("%s done k=%0d", tag, k), get_done(which), 1'b0);
    end
    @(negedge clk);
    chk($sformatf("%s busy_end", tag), get_busy(which), 1'b0);
    chk($sformatf("%s done_end", tag), get_done(which), 1'b1);
    chk($sformatf("%s tx_end", tag), get_tx(which), 1'b1);
  endtask

  task automatic idle_check(input int which, input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk($sformatf("%s idle busy c=%0d", tag, c), get_busy(which), 1'b0);
      chk($sformatf("%s idle done c=%0d", tag, c), get_done(which), 1'b0);
      chk($sformatf("%s idle tx c=%0d", tag, c), get_tx(which), 1'b1);
    end
  endtask

  initial begin
    ifa.tx_en = 1'b0; ifa.tx_data = 8'h00;
    ifb.tx_en = 1'b0; ifb.tx_data = 8'h00;

    vecs[0] = '{0, 8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{0, 8'h07, 10'b1000001110, 1'b1};
    vecs[2] = '{0, 8'h03, 10'b1000000110, 1'b0};
    vecs[3] = '{0, 8'h55, 10'b1010101010, 1'b0};
    vecs[4] = '{0, 8'hFF, 10'b1111111110, 1'b0};
    vecs[5] = '{1, 8'h80, 10'b1100000000, 1'b1};
    vecs[6] = '{1, 8'h01, 10'b1000000010, 1'b1};
    v3c     = '{0, 8'h3C, 10'b1001111000, 1'b0};
    vc3     = '{0, 8'hC3, 10'b1110000110, 1'b0};
    v00     = '{0, 8'h00, 10'b1000000000, 1'b0};
    va5     = '{0, 8'hA5, 10'b1101001010, 1'b0};
    v01     = '{0, 8'h01, 10'b1000000010, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset tx_a", tx_a, 1'b1);
    chk("reset busy_a", ifa.busy, 1'b0);
    chk("reset done_a", ifa.done, 1'b0);
    chk("reset tx_b", tx_b, 1'b1);
    chk("reset busy_b", ifb.busy, 1'b0);
    chk("reset done_b", ifb.done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single frames
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].dut, vecs[i].data);
      check_frame(vecs[i].dut, vecs[i], 1'b0, -1, 1'b0, vecs[i].data,
                  $sformatf("vec%0d", i));
      idle_check(vecs[i].dut, 2, $sformatf("vec%0d", i));
    end

    // Enable held high, data swapped mid-frame: back-to-back frames
    send(0, 8'h3C);
    check_frame(0, v3c, 1'b1, 5, 1'b1, 8'hC3, "hold1");
    check_frame(0, vc3, 1'b0, -1, 1'b0, 8'hC3, "hold2");
    idle_check(0, 3, "hold");

    // Enable pulse while busy is ignored
    send(0, 8'h00);
    check_frame(0, v00, 1'b0, 12, 1'b1, 8'hFF, "busyen");
    idle_check(0, 8, "busyen");

    // Reset mid-frame
    send(0, 8'hA5);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0) drive_en(0, 1'b0);
    end
    @(negedge clk);
    chk("midrst tx_before", tx_a, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst tx_async", tx_a, 1'b1);
    chk("midrst busy_async", ifa.busy, 1'b0);
    chk("midrst done_async", ifa.done, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("midrst done c=%0d", c), ifa.done, 1'b0);
      chk($sformatf("midrst busy c=%0d", c), ifa.busy, 1'b0);
    end
    reset = 1'b0;
    idle_check(0, 2, "postrst");
    send(0, 8'h01);
    check_frame(0, v01, 1'b0, -1, 1'b0, 8'h01, "postrst");
    idle_check(0, 2, "postrst_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
